clic_gateway: RTL and testbench

CLIC_GATEWAY -- requirements
Module: clic_gateway

---
 rtl/clic_gateway_pkg.sv | 15 +
 rtl/clic_gateway_src.sv | 79 +++++++
 rtl/clic_gateway.sv | 53 +++++
 tb/tb_clic_gateway.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/clic_gateway_pkg.sv
// clic_gateway_pkg: shared constants for the CLIC interrupt gateway.
//   - trigger-type encoding (attr.trig[0]) and polarity encoding (attr.trig[1])
//   - clic_id_width(): width of a claim id for a given source count (min 1)
package clic_gateway_pkg;

   localparam logic TRIG_LEVEL = 1'b0;
   localparam logic TRIG_EDGE  = 1'b1;
   localparam logic POL_HIGH   = 1'b0;  // high level / rising edge
   localparam logic POL_LOW    = 1'b1;  // low level / falling edge

   function automatic int clic_id_width(input int n_source);
      return (n_source > 1) ? $clog2(n_source) : 1;
   endfunction

endpackage

// File: rtl/clic_gateway_src.sv
// clic_gateway_src: per-source gateway slice.
//   Synchronizes one raw interrupt line, normalizes its polarity, detects
//   active edges and holds the pending bit.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   src_i            raw interrupt line (may be asynchronous)
//   le_i, tp_i       trigger type (0 level / 1 edge), polarity (0 high / 1 low)
//   ip_sw_i/_we_i    software write value / strobe
//   claim_hit_i      this source was claimed this cycle
//   ip_o             registered pending bit
module clic_gateway_src
   import clic_gateway_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic src_i,
   input  logic le_i,
   input  logic tp_i,
   input  logic ip_sw_i,
   input  logic ip_sw_we_i,
   input  logic claim_hit_i,
   output logic ip_o
);

   logic s, n, edge_hit;
   logic n_q, tp_q, ip_q, ip_d;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = src_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= src_i;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign n = (tp_i == POL_HIGH) ? s : ~s;

   // A polarity change flips n without any activity on the line; mask the
   // edge detector for that cycle so it is not mistaken for an interrupt.
   assign edge_hit = n & ~n_q & (tp_i == tp_q);

   always_comb begin
      ip_d = ip_q;
      if (le_i == TRIG_LEVEL) begin
         ip_d = n;
      end else begin
         // Edge is OR'd last so a fresh edge survives a claim or a SW clear.
         if (ip_sw_we_i)       ip_d = ip_sw_i;
         else if (claim_hit_i) ip_d = 1'b0;
         ip_d = ip_d | edge_hit;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q  <= 1'b0;
         tp_q <= 1'b0;
         ip_q <= 1'b0;
      end else begin
         n_q  <= n;
         tp_q <= tp_i;
         ip_q <= ip_d;
      end
   end

   assign ip_o = ip_q;

endmodule

// File: rtl/clic_gateway.sv
// clic_gateway: CLIC interrupt gateway for N_SOURCE sources.
//   Decodes the hardware claim id and instantiates one clic_gateway_src
//   slice per source.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   intr_src_i             raw interrupt lines
//   le_i, tp_i             per-source trigger type / polarity
//   ip_sw_i, ip_sw_we_i    per-source software write value / strobe
//   claim_valid_i/_id_i    hardware-vectored claim pulse and id
//   ip_o                   registered pending vector
module clic_gateway
   import clic_gateway_pkg::*;
#(
   parameter int N_SOURCE    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int IdWidth     = clic_id_width(N_SOURCE)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] intr_src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] tp_i,
   input  logic [N_SOURCE-1:0] ip_sw_i,
   input  logic [N_SOURCE-1:0] ip_sw_we_i,
   input  logic                claim_valid_i,
   input  logic [IdWidth-1:0]  claim_id_i,
   output logic [N_SOURCE-1:0] ip_o
);

   logic [N_SOURCE-1:0] claim_hit;

   generate
      for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
         // Ids >= N_SOURCE match no slice and are silently dropped.
         assign claim_hit[i] = claim_valid_i && (claim_id_i == IdWidth'(i));

         clic_gateway_src #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_src (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .src_i       (intr_src_i[i]),
            .le_i        (le_i[i]),
            .tp_i        (tp_i[i]),
            .ip_sw_i     (ip_sw_i[i]),
            .ip_sw_we_i  (ip_sw_we_i[i]),
            .claim_hit_i (claim_hit[i]),
            .ip_o        (ip_o[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clic_gateway.sv
// tb_clic_gateway: directed table-driven bench for clic_gateway
// (N_SOURCE=12 so that ids 12..15 are representable but out of range).
module tb_clic_gateway;

   localparam int NS = 12;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NS-1:0] src, le, tp, sw, swe, ip;
   logic          cv;
   logic [IW-1:0] cid;

   int n_cmp  = 0;
   int n_fail = 0;

   clic_gateway #(.N_SOURCE(NS), .SYNC_STAGES(2), .IdWidth(IW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .intr_src_i    (src),
      .le_i          (le),
      .tp_i          (tp),
      .ip_sw_i       (sw),
      .ip_sw_we_i    (swe),
      .claim_valid_i (cv),
      .claim_id_i    (cid),
      .ip_o          (ip)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NS-1:0] src, tp, le, sw, swe;
      logic          cv;
      logic [IW-1:0] cid;
      logic [NS-1:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [NS-1:0] s, t, l, w, we, input logic v,
                      input logic [IW-1:0] id, input logic [NS-1:0] e);
      vec_t r;
      r.src = s; r.tp = t; r.le = l; r.sw = w; r.swe = we;
      r.cv = v; r.cid = id; r.exp = e;
      tbl.push_back(r);
   endtask

   task automatic check(input string name, input logic [NS-1:0] act, exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: ip_o=%h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Baseline: src5 idles high (tp5=1, falling-edge source); edge on 2,5,7.
   localparam logic [NS-1:0] TP0 = 12'h020;
   localparam logic [NS-1:0] LE0 = 12'h0A4;

   initial begin
      rst_n = 1'b0; src = 12'h020; le = LE0; tp = TP0;
      sw = '0; swe = '0; cv = 1'b0; cid = '0;

      // Row r drives inputs before edge r; ip after edge r is compared.
      // A raw change in row r reaches ip after edge r+2.
      //   src      tp      le      sw      swe     cv  cid  exp
      add(12'h028, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h000); // r0 src3 rises (level)
      add(12'h028, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h000);
      add(12'h028, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008); // r2 level latency 3
      add(12'h008, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008); // r3 src5 falls
      add(12'h008, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008);
      add(12'h008, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h028); // r5 falling edge pending
      add(12'h008, TP0,    LE0,    12'h0, 12'h0,  1, 5,  12'h008); // r6 claim 5, src low
      add(12'h028, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008);
      add(12'h0A8, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008); // r8 src7 rises
      add(12'h0A8, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008);
      add(12'h0A8, TP0,    LE0,    12'h0, 12'h0,  1, 7,  12'h088); // r10 edge+claim 7
      add(12'h0A8, TP0,    LE0,    12'h0, 12'h0,  1, 7,  12'h008); // r11 claim clears
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008); // r12 src3,src7 fall
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h008);
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h000); // r14 level drops
      add(12'h020, 12'h024,LE0,    12'h0, 12'h0,  0, 0,  12'h000); // r15 tp2 toggles
      add(12'h020, 12'h024,LE0,    12'h0, 12'h0,  0, 0,  12'h000);
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h000);
      add(12'h020, TP0,    LE0,    12'h4, 12'h4,  0, 0,  12'h004); // r18 sw write 1
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  1, 12, 12'h004); // r19 id=N_SOURCE
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  1, 15, 12'h004);
      add(12'h020, TP0,    LE0,    12'h4, 12'h4,  1, 2,  12'h004); // r21 sw beats claim
      add(12'h020, TP0,    LE0,    12'h0, 12'h0,  1, 2,  12'h000); // r22 claim 2
      add(12'h020, TP0,    LE0,    12'h8, 12'h8,  0, 0,  12'h000); // r23 sw on level ignored
      add(12'h0A0, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h000); // r24 src7 rises
      add(12'h0A0, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h000);
      add(12'h0A0, TP0,    LE0,    12'h0, 12'h80, 0, 0,  12'h080); // r26 edge beats sw 0
      add(12'h0A0, TP0,    LE0,    12'h0, 12'h80, 0, 0,  12'h000); // r27 sw 0 clears
      add(12'h0A0, TP0,    12'h024,12'h0, 12'h0,  0, 0,  12'h080); // r28 edge->level
      add(12'h0A0, TP0,    LE0,    12'h0, 12'h0,  0, 0,  12'h080); // r29 level->edge keeps
      add(12'h0A0, TP0,    LE0,    12'h0, 12'h0,  1, 7,  12'h000); // r30 claim 7

      repeat (3) @(posedge clk);
      #1 check("reset_state", ip, '0);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("settle_idle", ip, '0);

      foreach (tbl[i]) begin
         @(negedge clk);
         src = tbl[i].src; tp = tbl[i].tp; le = tbl[i].le;
         sw = tbl[i].sw; swe = tbl[i].swe; cv = tbl[i].cv; cid = tbl[i].cid;
         @(posedge clk);
         #1 check($sformatf("row%0d", i), ip, tbl[i].exp);
      end

      // Async reset mid-operation, with a SW write in flight; src7 held high.
      @(negedge clk);
      sw = 12'h004; swe = 12'h004; cv = 1'b0; cid = '0;
      @(posedge clk);
      #1 check("sw_set_pre_reset", ip, 12'h004);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_clear", ip, '0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 check($sformatf("in_reset%0d", k), ip, '0);
         sw = '0; swe = '0;
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 check("post_rel1", ip, '0);
      @(posedge clk); #1 check("post_rel2", ip, '0);
      @(posedge clk); #1 check("post_rel3_held_edge", ip, 12'h080);
      @(posedge clk); #1 check("post_rel4_stays", ip, 12'h080);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
